// File: rtl/pfvf_route_pkg.sv
// Shared PF/VF routing definitions for pfvf_req_router.
// Provides function port indices, the per-function {pf, vf, va} tags, the
// route_tag_t struct, the constant decode table, and pfvf_decode(), which
// maps a request tag to its owning function port (DEFAULT_IDX when no entry matches).
package pfvf_route_pkg;

  localparam int unsigned PF_WIDTH   = 3;
  localparam int unsigned VF_WIDTH   = 11;
  localparam int unsigned NUM_FUNC_C = 5;
  localparam int unsigned DEST_W     = 3;

  localparam int unsigned HLB_IDX     = 0;
  localparam int unsigned HEM_IDX     = 1;
  localparam int unsigned HEH_IDX     = 2;
  localparam int unsigned HEM_TG_IDX  = 3;
  localparam int unsigned ST2MM_IDX   = 4;
  localparam int unsigned DEFAULT_IDX = NUM_FUNC_C;

  localparam logic [PF_WIDTH-1:0] HLB_PF    = 3'd1;
  localparam logic [VF_WIDTH-1:0] HLB_VF    = 11'd0;
  localparam logic                HLB_VA    = 1'b0;
  localparam logic [PF_WIDTH-1:0] HEM_PF    = 3'd0;
  localparam logic [VF_WIDTH-1:0] HEM_VF    = 11'd0;
  localparam logic                HEM_VA    = 1'b1;
  localparam logic [PF_WIDTH-1:0] HEH_PF    = 3'd0;
  localparam logic [VF_WIDTH-1:0] HEH_VF    = 11'd1;
  localparam logic                HEH_VA    = 1'b1;
  localparam logic [PF_WIDTH-1:0] HEM_TG_PF = 3'd0;
  localparam logic [VF_WIDTH-1:0] HEM_TG_VF = 11'd2;
  localparam logic                HEM_TG_VA = 1'b1;
  localparam logic [PF_WIDTH-1:0] ST2MM_PF  = 3'd0;
  localparam logic [VF_WIDTH-1:0] ST2MM_VF  = 11'd0;
  localparam logic                ST2MM_VA  = 1'b0;

  typedef struct packed {
    logic [PF_WIDTH-1:0] pf;
    logic [VF_WIDTH-1:0] vf;
    logic                va;
  } route_tag_t;

  typedef enum logic [0:0] {StIdle, StPkt} route_state_e;

  localparam route_tag_t ROUTE_TBL [NUM_FUNC_C] = '{
    '{pf: HLB_PF,    vf: HLB_VF,    va: HLB_VA},
    '{pf: HEM_PF,    vf: HEM_VF,    va: HEM_VA},
    '{pf: HEH_PF,    vf: HEH_VF,    va: HEH_VA},
    '{pf: HEM_TG_PF, vf: HEM_TG_VF, va: HEM_TG_VA},
    '{pf: ST2MM_PF,  vf: ST2MM_VF,  va: ST2MM_VA}
  };

  // A PF-only tag (va=0) never compares the VF field.
  function automatic logic [DEST_W-1:0] pfvf_decode(route_tag_t tag);
    logic [DEST_W-1:0] idx;
    idx = DEST_W'(DEFAULT_IDX);
    for (int i = NUM_FUNC_C - 1; i >= 0; i--) begin
      if ((tag.pf == ROUTE_TBL[i].pf) && (tag.va == ROUTE_TBL[i].va) &&
          (!tag.va || (tag.vf == ROUTE_TBL[i].vf))) begin
        idx = DEST_W'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/pfvf_skid_buf.sv
// Two-entry valid/ready output buffer carrying {dest, sop, eop, data}.
// Ports: clk_i/rst_i (async active-high), in_* push side with in_ready_o
// (low only when both entries are occupied), out_* head entry with out_ready_i.
// The head is driven straight from flops, so it is stable while not popped.
module pfvf_skid_buf #(
  parameter int unsigned DataW = 512,
  parameter int unsigned DestW = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [DestW-1:0] in_dest_i,
  input  logic             in_sop_i,
  input  logic             in_eop_i,
  input  logic [DataW-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [DestW-1:0] out_dest_o,
  output logic             out_sop_o,
  output logic             out_eop_o,
  output logic [DataW-1:0] out_data_o
);

  localparam int unsigned EntW = DestW + 2 + DataW;

  logic [EntW-1:0] mem_q [2];
  logic [1:0]      cnt_q;
  logic            wr_ptr_q, rd_ptr_q;
  logic            push, pop;

  assign in_ready_o  = ~cnt_q[1];
  assign out_valid_o = (cnt_q != 2'd0);
  assign push        = in_valid_i & in_ready_o;
  assign pop         = out_valid_o & out_ready_i;

  assign {out_dest_o, out_sop_o, out_eop_o, out_data_o} = mem_q[rd_ptr_q];

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      cnt_q    <= 2'd0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {in_dest_i, in_sop_i, in_eop_i, in_data_i};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      cnt_q <= cnt_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/pfvf_req_router.sv
// PF/VF request router: steers host-to-FPGA packets, tagged on their SOP beat
// with {pf, vf, va}, to the owning function port (HLB, HEM, HEH, HEM_TG,
// ST2MM) or to the default port NUM_FUNC when the tag matches nothing.
// Ports: clk, rst (async active-high); rx_* input beat stream with tag;
// tx_valid/tx_ready one-hot per-port handshake with shared tx_data/sop/eop;
// err_unmatched / err_framing one-cycle pulses; unmatched_cnt saturating;
// pkt_cnt per-port delivered-EOP counts, live only when PFVF_ROUTER_PKT_CNT_EN
// is defined (otherwise tied to zero).
module pfvf_req_router
  import pfvf_route_pkg::*;
#(
  parameter int unsigned DATA_W   = 512,
  parameter int unsigned PF_W     = PF_WIDTH,
  parameter int unsigned VF_W     = VF_WIDTH,
  parameter int unsigned NUM_FUNC = NUM_FUNC_C
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  input  logic [DATA_W-1:0]          rx_data,
  input  logic                       rx_sop,
  input  logic                       rx_eop,
  input  logic [PF_W-1:0]            rx_pf,
  input  logic [VF_W-1:0]            rx_vf,
  input  logic                       rx_va,
  output logic [NUM_FUNC:0]          tx_valid,
  input  logic [NUM_FUNC:0]          tx_ready,
  output logic [DATA_W-1:0]          tx_data,
  output logic                       tx_sop,
  output logic                       tx_eop,
  output logic                       err_unmatched,
  output logic                       err_framing,
  output logic [15:0]                unmatched_cnt,
  output logic [(NUM_FUNC+1)*16-1:0] pkt_cnt
);

  localparam int unsigned NumPorts = NUM_FUNC + 1;

  route_state_e      state_q;
  logic [DEST_W-1:0] dest_q;
  route_tag_t        rx_tag;
  logic [DEST_W-1:0] sop_dest, push_dest;
  logic              acc, fwd, skid_ready;
  logic              head_valid, head_ready;
  logic [DEST_W-1:0] head_dest;

  assign rx_tag    = '{pf: rx_pf, vf: rx_vf, va: rx_va};
  assign sop_dest  = pfvf_decode(rx_tag);
  assign rx_ready  = skid_ready & ~rst;
  assign acc       = rx_valid & rx_ready;
  // Non-SOP beats seen in IDLE have no owner and are dropped.
  assign fwd       = acc & (rx_sop | (state_q == StPkt));
  assign push_dest = rx_sop ? sop_dest : dest_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= StIdle;
      dest_q        <= DEST_W'(DEFAULT_IDX);
      err_unmatched <= 1'b0;
      err_framing   <= 1'b0;
      unmatched_cnt <= 16'd0;
    end else begin
      err_unmatched <= 1'b0;
      err_framing   <= 1'b0;
      if (acc) begin
        if (rx_sop) begin
          // An SOP inside a packet abandons the old one and reroutes.
          dest_q  <= sop_dest;
          state_q <= rx_eop ? StIdle : StPkt;
          if (state_q == StPkt) begin
            err_framing <= 1'b1;
          end
          if (sop_dest == DEST_W'(DEFAULT_IDX)) begin
            err_unmatched <= 1'b1;
            if (unmatched_cnt != 16'hFFFF) begin
              unmatched_cnt <= unmatched_cnt + 16'd1;
            end
          end
        end else if (state_q == StIdle) begin
          err_framing <= 1'b1;
        end else if (rx_eop) begin
          state_q <= StIdle;
        end
      end
    end
  end

  pfvf_skid_buf #(
    .DataW (DATA_W),
    .DestW (DEST_W)
  ) u_skid (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (fwd),
    .in_ready_o  (skid_ready),
    .in_dest_i   (push_dest),
    .in_sop_i    (rx_sop),
    .in_eop_i    (rx_eop),
    .in_data_i   (rx_data),
    .out_valid_o (head_valid),
    .out_ready_i (head_ready),
    .out_dest_o  (head_dest),
    .out_sop_o   (tx_sop),
    .out_eop_o   (tx_eop),
    .out_data_o  (tx_data)
  );

  // Only the head entry's own port can release it.
  assign head_ready = tx_ready[head_dest];
  assign tx_valid   = head_valid ? (NumPorts'(1) << head_dest) : '0;

`ifdef PFVF_ROUTER_PKT_CNT_EN
  logic [NUM_FUNC:0][15:0] pkt_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pkt_cnt_q <= '0;
    end else if (head_valid && head_ready && tx_eop &&
                 (pkt_cnt_q[head_dest] != 16'hFFFF)) begin
      pkt_cnt_q[head_dest] <= pkt_cnt_q[head_dest] + 16'd1;
    end
  end

  assign pkt_cnt = pkt_cnt_q;
`else
  assign pkt_cnt = '0;
`endif

endmodule

// File: doc/pfvf_req_router.md
Name: pfvf_req_router

Overview:
- Device-side counterpart of the host PF/VF addressing scheme: takes the host-to-FPGA request stream tagged with {pf, vf, vf_active} and steers each packet to the owning accelerator function port.
- Functions: HLB, HEM, HEH, HEM_TG, ST2MM, plus one default/error port for unmatched tags.
- Sits between the PCIe RX demux and the AFU function ports.
- Provides packet-atomic routing, a one-cycle registered output stage with skid buffering, and unmatched/framing error reporting.

Parameters:
- DATA_W, 512, payload width.
- PF_W, 3, PF number width.
- VF_W, 11, VF number width.
- NUM_FUNC, 5, number of decoded functions; port index NUM_FUNC is the default port.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- rx_valid  in  1  input beat valid
- rx_ready  out  1  input beat accepted when rx_valid&rx_ready
- rx_data  in  DATA_W  payload
- rx_sop  in  1  first beat of packet; carries routing tag
- rx_eop  in  1  last beat of packet
- rx_pf  in  PF_W  PF number, sampled on SOP beat
- rx_vf  in  VF_W  VF number, sampled on SOP beat
- rx_va  in  1  vf_active, sampled on SOP beat
- tx_valid  out  NUM_FUNC+1  one-hot per-port valid
- tx_ready  in  NUM_FUNC+1  per-port ready
- tx_data  out  DATA_W  shared payload to all ports
- tx_sop  out  1  shared
- tx_eop  out  1  shared
- err_unmatched  out  1  one-cycle pulse when an SOP routes to the default port
- err_framing  out  1  one-cycle pulse on a framing violation
- unmatched_cnt  out  16  saturating count of unmatched packets

Behaviour:
- Reset:
  - tx_valid=0, tx_sop=0, tx_eop=0, tx_data=0.
  - err_*=0, unmatched_cnt=0.
  - FSM=IDLE, skid buffer empty.
  - rx_ready=0 while rst is asserted, 1 in the first cycle after deassertion.
- Decode table (shared package): index 0 HLB {1,0,0}, 1 HEM {0,0,1}, 2 HEH {0,1,1}, 3 HEM_TG {0,2,1}, 4 ST2MM {0,0,0}.
  - When va=0, vf is ignored in the compare.
  - No match selects port NUM_FUNC.
- FSM states:
  - IDLE:
    - Accepted beat with sop=1: decode, latch dest, forward the beat. Go to PKT, or stay in IDLE if eop=1 on the same beat (single-beat packet).
    - Accepted beat with sop=0: drop it and pulse err_framing.
  - PKT:
    - Forward beats to the latched dest.
    - Accepted beat with sop=1: treat as a new packet; decode and reroute, pulse err_framing.
    - Accepted eop returns to IDLE.
- Latency: accepted beat appears on tx_* the next cycle.
- Output stage: 2-entry skid.
  - rx_ready = skid not full.
  - tx_valid[dest] holds until tx_ready[dest]=1.
  - Data, sop and eop are stable while valid and not ready.
- Only tx_ready[dest of head entry] is honoured; ready on other ports is ignored.
- Back-to-back packets to different ports: no bubble required; order is preserved.
- unmatched_cnt saturates at 16'hFFFF; err_unmatched fires on the accepted SOP beat.
- rst asserted mid-packet: the partial packet is lost and all state clears immediately (async). No recovery of in-flight beats.

Optional Feature:
- Macro PFVF_ROUTER_PKT_CNT_EN.
- Defined:
  - Adds output pkt_cnt, (NUM_FUNC+1)*16 bits: per-port saturating count of EOPs delivered on tx (counted when valid&ready&eop).
  - Counts reset to 0.
- Undefined: the port still exists and is driven to 0, with no counter flops.

Decomposition:
- Package pfvf_route_pkg:
  - Function index localparams (HLB_IDX .. ST2MM_IDX, DEFAULT_IDX).
  - Per-function PF/VF/VA constants.
  - typedef struct route_tag_t {pf, vf, va}.
  - Constant table array of route_tag_t.
  - Function pfvf_decode(route_tag_t) returning an index.
- Sub-module pfvf_skid_buf: 2-entry valid/ready skid carrying {dest, sop, eop, data}.

Test Plan:
- Reset, then SOP+EOP beat with pf=1, vf=0, va=0, data=0xA5 -> tx_valid=6'b000001 next cycle, tx_data=0xA5, err_*=0.
- 3-beat packet tagged pf=0, vf=2, va=1 with tx_ready[3] low 4 cycles -> tx_valid[3] held, data stable; rx_ready drops after 2 beats buffered; all 3 beats delivered in order, no other port asserts.
- SOP tagged pf=2, vf=5, va=1 -> routed to port 5, err_unmatched pulses once, unmatched_cnt=1; 65536 such packets -> count stays 0xFFFF.
- Non-SOP beat in IDLE -> dropped, err_framing=1 for one cycle, no tx_valid.
- Packets to HEH then ST2MM back-to-back, all ready high -> consecutive cycles on ports 2 then 4, no gap.
- rst asserted mid-packet -> tx_valid=0 asynchronously; after release, a fresh SOP to HEM routes to port 1 correctly. With PFVF_ROUTER_PKT_CNT_EN: port counts reset to 0 and count only completed EOPs.
